// File: rtl/conv_mac_engine.sv
// Time-multiplexed multi-channel KxK convolution MAC engine.
// One (filter, channel) pair is reduced per cycle; each filter result gets bias,
// arithmetic shift, optional ReLU and saturation before landing in its output slot.
module conv_mac_engine #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned IN_CHANNEL   = 3,
  parameter int unsigned NUM_FILTERS  = 3,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned OUT_SHIFT    = 0,
  parameter int unsigned OUT_SIGNED   = 0,
  localparam int unsigned Taps  = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned AddrW = $clog2(NUM_FILTERS * IN_CHANNEL + NUM_FILTERS),
  localparam int unsigned CfgW  = (Taps * WEIGHT_WIDTH > ACC_WIDTH) ? Taps * WEIGHT_WIDTH
                                                                   : ACC_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [IN_CHANNEL*Taps*DATA_WIDTH-1:0]   in_window,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    relu_en,
  input  logic                                    cfg_we,
  input  logic [AddrW-1:0]                        cfg_addr,
  input  logic [CfgW-1:0]                         cfg_wdata,
  output logic                                    cfg_err,
  output logic [NUM_FILTERS*DATA_WIDTH-1:0]       out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready
);

  localparam int unsigned NumWords = NUM_FILTERS * IN_CHANNEL;
  localparam int unsigned WIdxW    = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned ChW      = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;
  localparam int unsigned FiW      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned PW       = DATA_WIDTH + WEIGHT_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] SatMax = (OUT_SIGNED != 0)
      ? ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1)
      : ACC_WIDTH'((64'sd1 <<< DATA_WIDTH) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = (OUT_SIGNED != 0)
      ? ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)))
      : '0;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e state_q, state_d;

  logic [IN_CHANNEL*Taps*DATA_WIDTH-1:0] win_q;
  logic                                  relu_q;
  logic signed [ACC_WIDTH-1:0]           acc_q;
  logic [ChW-1:0]                        c_q;
  logic [FiW-1:0]                        f_q;
  logic [NUM_FILTERS*DATA_WIDTH-1:0]     out_q;
  logic                                  cfg_err_q;

  logic [Taps*WEIGHT_WIDTH-1:0]          weight_q [NumWords];
  logic signed [ACC_WIDTH-1:0]           bias_q   [NUM_FILTERS];

  logic                                  accept, last_c, last_f;
  logic                                  cfg_in_range, cfg_is_bias, cfg_ok;
  logic [WIdxW-1:0]                      cfg_widx, cur_widx;
  logic [FiW-1:0]                        cfg_bidx;
  logic [Taps*WEIGHT_WIDTH-1:0]          cur_word;
  logic [Taps*DATA_WIDTH-1:0]            chan;
  logic signed [DATA_WIDTH:0]            px;
  logic signed [WEIGHT_WIDTH-1:0]        wt;
  logic signed [PW-1:0]                  prod;
  logic signed [ACC_WIDTH-1:0]           partial, final_v, shifted;
  logic [DATA_WIDTH-1:0]                 sat_val;

  assign accept = in_valid & in_ready;
  assign last_c = (c_q == ChW'(IN_CHANNEL - 1));
  assign last_f = (f_q == FiW'(NUM_FILTERS - 1));

  // Config address decode; writes land only while idle and in range.
  always_comb begin
    cfg_in_range = (32'(cfg_addr) < NumWords + NUM_FILTERS);
    cfg_is_bias  = (32'(cfg_addr) >= NumWords);
    cfg_ok       = cfg_we & (state_q == StIdle) & cfg_in_range;
    cfg_widx     = WIdxW'(cfg_addr);
    cfg_bidx     = FiW'(32'(cfg_addr) - NumWords);
  end

  // Weight/bias storage and dropped-write error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumWords; i++) weight_q[i] <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) bias_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we & ~cfg_ok;
      if (cfg_ok) begin
        if (cfg_is_bias) bias_q[cfg_bidx] <= cfg_wdata[ACC_WIDTH-1:0];
        else             weight_q[cfg_widx] <= cfg_wdata[Taps*WEIGHT_WIDTH-1:0];
      end
    end
  end

  // Dot product of one channel window against one weight word, then finalisation.
  always_comb begin
    cur_widx = WIdxW'(32'(f_q) * IN_CHANNEL + 32'(c_q));
    cur_word = weight_q[cur_widx];
    chan     = win_q[32'(c_q)*Taps*DATA_WIDTH +: Taps*DATA_WIDTH];
    px       = '0;
    wt       = '0;
    prod     = '0;
    partial  = '0;
    for (int t = 0; t < Taps; t++) begin
      px      = signed'({1'b0, chan[t*DATA_WIDTH +: DATA_WIDTH]});
      wt      = signed'(cur_word[t*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      prod    = PW'(px) * PW'(wt);
      partial = partial + ACC_WIDTH'(prod);
    end
    final_v = acc_q + partial + bias_q[f_q];
    shifted = final_v >>> OUT_SHIFT;
    if (relu_q && shifted < 0) shifted = '0;
    if (shifted > SatMax)      sat_val = SatMax[DATA_WIDTH-1:0];
    else if (shifted < SatMin) sat_val = SatMin[DATA_WIDTH-1:0];
    else                       sat_val = shifted[DATA_WIDTH-1:0];
  end

  // Window latch, accumulator, pair counters and output slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      relu_q <= 1'b0;
      acc_q  <= '0;
      c_q    <= '0;
      f_q    <= '0;
      out_q  <= '0;
    end else if (accept) begin
      win_q  <= in_window;
      relu_q <= relu_en;
      acc_q  <= '0;
      c_q    <= '0;
      f_q    <= '0;
    end else if (state_q == StCompute) begin
      if (last_c) begin
        acc_q <= '0;
        c_q   <= '0;
        f_q   <= last_f ? '0 : f_q + FiW'(1);
        out_q[32'(f_q)*DATA_WIDTH +: DATA_WIDTH] <= sat_val;
      end else begin
        acc_q <= acc_q + partial;
        c_q   <= c_q + ChW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE chains straight into COMPUTE when a window is waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StCompute;
      StCompute: if (last_c && last_f) state_d = StDone;
      StDone:    if (out_ready) state_d = in_valid ? StCompute : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = ~rst & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    out_valid = (state_q == StDone);
    out_data  = out_q;
    cfg_err   = cfg_err_q;
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench: three engines (unsigned, signed, signed with shift 2) share stimulus
// and are compared against a plain-arithmetic convolution model.
module tb_conv_mac_engine;

  localparam int DW = 8;
  localparam int T  = 9;
  localparam int C  = 3;
  localparam int F  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [C*T*DW-1:0] in_window = '0;
  logic              in_valid  = 1'b0;
  logic              relu_en   = 1'b0;
  logic              cfg_we    = 1'b0;
  logic [3:0]        cfg_addr  = '0;
  logic [71:0]       cfg_wdata = '0;
  logic              out_ready = 1'b0;

  logic [23:0] od [3];
  logic        ov [3];
  logic        ir [3];
  logic        ce [3];

  int errors = 0;
  int checks = 0;

  // Model state: weights, biases, current window pixels and relu flag.
  int mw   [F][C][T];
  int mb   [F];
  int mpix [C][T];
  bit mrelu;

  conv_mac_engine #(.OUT_SIGNED(0), .OUT_SHIFT(0)) dut_u (
    .clk(clk), .rst(rst), .in_window(in_window), .in_valid(in_valid), .in_ready(ir[0]),
    .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(ce[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready));

  conv_mac_engine #(.OUT_SIGNED(1), .OUT_SHIFT(0)) dut_s (
    .clk(clk), .rst(rst), .in_window(in_window), .in_valid(in_valid), .in_ready(ir[1]),
    .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(ce[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready));

  conv_mac_engine #(.OUT_SIGNED(1), .OUT_SHIFT(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_window(in_window), .in_valid(in_valid), .in_ready(ir[2]),
    .relu_en(relu_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(ce[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready));

  // Expected packed result for engine k (0: unsigned, 1: signed, 2: signed >>> 2).
  function automatic logic [23:0] model_out(input int k);
    logic [23:0]        r;
    longint             sum, s, lo, hi;
    logic signed [23:0] v;
    r = '0;
    for (int f = 0; f < F; f++) begin
      sum = longint'(mb[f]);
      for (int c = 0; c < C; c++)
        for (int t = 0; t < T; t++)
          sum += longint'(mpix[c][t]) * longint'(mw[f][c][t]);
      v  = 24'(sum);
      s  = longint'(v) >>> ((k == 2) ? 2 : 0);
      if (mrelu && s < 0) s = 0;
      lo = (k != 0) ? -128 : 0;
      hi = (k != 0) ? 127 : 255;
      if (s < lo) s = lo;
      if (s > hi) s = hi;
      r[f*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic logic [71:0] pack_w(input int f, input int c);
    logic [71:0] w;
    w = '0;
    for (int t = 0; t < T; t++) w[t*8 +: 8] = 8'(mw[f][c][t]);
    return w;
  endfunction

  task automatic set_uniform(input int w, input int b0, input int b1, input int b2);
    for (int f = 0; f < F; f++)
      for (int c = 0; c < C; c++)
        for (int t = 0; t < T; t++) mw[f][c][t] = w;
    mb[0] = b0; mb[1] = b1; mb[2] = b2;
  endtask

  task automatic fill_pix(input int v);
    for (int c = 0; c < C; c++)
      for (int t = 0; t < T; t++) mpix[c][t] = v;
  endtask

  task automatic rand_pix();
    for (int c = 0; c < C; c++)
      for (int t = 0; t < T; t++) mpix[c][t] = int'($urandom_range(255));
  endtask

  task automatic apply_window();
    for (int c = 0; c < C; c++)
      for (int t = 0; t < T; t++) in_window[(c*T+t)*8 +: 8] = 8'(mpix[c][t]);
    relu_en = mrelu;
  endtask

  task automatic cfg_write(input int a, input logic [71:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(a);
    cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic load_all();
    logic [23:0] b;
    for (int a = 0; a < F*C; a++) cfg_write(a, pack_w(a / C, a % C));
    for (int f = 0; f < F; f++) begin
      b = 24'(mb[f]);
      cfg_write(F*C + f, {48'd0, b});
    end
  endtask

  task automatic start_window();
    apply_window();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges until out_valid, bounded at 64.
  task automatic wait_valid(output int n);
    n = 0;
    while (!ov[0] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready_low dut%0d: got %b, expected 0", k, ir[k]);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || od[k] !== 24'h0 || ce[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got ready=%b valid=%b data=%h err=%b, expected 1 0 000000 0",
                 k, ir[k], ov[k], od[k], ce[k]);
      end
    end
  endtask

  task automatic test_basic();
    int n;
    logic [23:0] e;
    set_uniform(1, 0, 0, 0);
    fill_pix(5);
    mrelu = 1'b0;
    load_all();
    start_window();
    wait_valid(n);
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, expected 9", n);
    end
    checks++;
    if (od[0] !== 24'h878787) begin
      errors++;
      $display("FAIL basic_value: got %h, expected 878787", od[0]);
    end
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (od[k] !== e || ov[k] !== 1'b1) begin
        errors++;
        $display("FAIL basic_model dut%0d: got data=%h valid=%b, expected %h valid=1",
                 k, od[k], ov[k], e);
      end
    end
    pop();
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_return_idle: got valid=%b ready=%b, expected 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_bias_sat();
    int n;
    logic [23:0] e;
    set_uniform(1, -35, 200, 0);
    fill_pix(5);
    mrelu = 1'b0;
    load_all();
    start_window();
    wait_valid(n);
    checks++;
    if (od[0] !== 24'h87FF64) begin
      errors++;
      $display("FAIL bias_sat_value: got %h, expected 87ff64", od[0]);
    end
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (od[k] !== e) begin
        errors++;
        $display("FAIL bias_sat_model dut%0d: got %h, expected %h", k, od[k], e);
      end
    end
    pop();
    set_uniform(-1, 0, 0, 0);
    load_all();
    start_window();
    wait_valid(n);
    checks++;
    if (od[0] !== 24'h000000 || od[1] !== 24'h808080 || od[2] !== 24'hDEDEDE) begin
      errors++;
      $display("FAIL negative_clamp: got %h %h %h, expected 000000 808080 dedede",
               od[0], od[1], od[2]);
    end
    pop();
    mrelu = 1'b1;
    start_window();
    wait_valid(n);
    checks++;
    if (od[0] !== 24'h0 || od[1] !== 24'h0 || od[2] !== 24'h0) begin
      errors++;
      $display("FAIL relu_zero: got %h %h %h, expected all 000000", od[0], od[1], od[2]);
    end
    pop();
    mrelu = 1'b0;
  endtask

  task automatic test_random();
    int n;
    logic [23:0] e;
    logic signed [23:0] rb;
    for (int it = 0; it < 16; it++) begin
      for (int f = 0; f < F; f++) begin
        for (int c = 0; c < C; c++)
          for (int t = 0; t < T; t++) mw[f][c][t] = int'($urandom_range(255)) - 128;
        rb = (it % 2 == 0) ? 24'($urandom) : 24'(int'($urandom_range(4000)) - 2000);
        mb[f] = int'(rb);
      end
      rand_pix();
      mrelu = 1'($urandom_range(1));
      load_all();
      start_window();
      wait_valid(n);
      checks++;
      if (n != 9) begin
        errors++;
        $display("FAIL random_latency it%0d: got %0d, expected 9", it, n);
      end
      for (int k = 0; k < 3; k++) begin
        e = model_out(k);
        checks++;
        if (od[k] !== e) begin
          errors++;
          $display("FAIL random_model it%0d dut%0d: got %h, expected %h", it, k, od[k], e);
        end
      end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [23:0] held [3];
    logic [23:0] e;
    rand_pix();
    mrelu = 1'b0;
    start_window();
    wait_valid(n);
    for (int k = 0; k < 3; k++) held[k] = od[k];
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (held[k] !== e) begin
        errors++;
        $display("FAIL backpressure_first dut%0d: got %h, expected %h", k, held[k], e);
      end
    end
    rand_pix();
    apply_window();
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (od[k] !== held[k] || ov[k] !== 1'b1 || ir[k] !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_hold cyc%0d dut%0d: got data=%h valid=%b ready=%b, expected %h 1 0",
                   cyc, k, od[k], ov[k], ir[k], held[k]);
        end
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_ready: got %b, expected 1", ir[0]);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ov[0] !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drop: got valid=%b, expected 0", ov[0]);
    end
    wait_valid(n);
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL back_to_back_latency: got %0d, expected 9", n);
    end
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (od[k] !== e) begin
        errors++;
        $display("FAIL back_to_back_model dut%0d: got %h, expected %h", k, od[k], e);
      end
    end
    pop();
  endtask

  task automatic test_cfg_protect();
    int n;
    logic [23:0] e;
    set_uniform(1, 0, 0, 0);
    fill_pix(5);
    mrelu = 1'b0;
    load_all();
    start_window();
    cfg_write(0, {9{8'h03}});
    checks++;
    if (ce[0] !== 1'b1 || ce[1] !== 1'b1 || ce[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_busy_err: got %b%b%b, expected 111", ce[0], ce[1], ce[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (ce[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_one_pulse: got %b, expected 0", ce[0]);
    end
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (od[k] !== e) begin
        errors++;
        $display("FAIL cfg_busy_unchanged dut%0d: got %h, expected %h", k, od[k], e);
      end
    end
    pop();
    cfg_write(12, '1);
    checks++;
    if (ce[0] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_range_err: got %b, expected 1", ce[0]);
    end
    // Bias write in the same cycle as acceptance applies to that window.
    mb[0] = 10;
    apply_window();
    cfg_we    = 1'b1;
    cfg_addr  = 4'd9;
    cfg_wdata = 72'd10;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (ce[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_accept_same_cycle_err: got %b, expected 0", ce[0]);
    end
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (od[k] !== e) begin
        errors++;
        $display("FAIL cfg_same_cycle dut%0d: got %h, expected %h", k, od[k], e);
      end
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [23:0] e;
    fill_pix(5);
    mrelu = 1'b0;
    start_window();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || od[k] !== 24'h0 || ir[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got valid=%b data=%h ready=%b, expected 0 000000 0",
                 k, ov[k], od[k], ir[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_uniform(0, 0, 0, 0);
    start_window();
    wait_valid(n);
    checks++;
    if (n != 9 || od[0] !== 24'h0 || od[2] !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_cleared_cfg: got n=%0d data=%h/%h, expected 9 000000",
               n, od[0], od[2]);
    end
    pop();
    set_uniform(1, 0, 0, 0);
    load_all();
    start_window();
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      e = model_out(k);
      checks++;
      if (od[k] !== e) begin
        errors++;
        $display("FAIL reset_mid_fresh dut%0d: got %h, expected %h", k, od[k], e);
      end
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_sat();
    test_random();
    test_back_to_back();
    test_cfg_protect();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
